// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  localparam logic GNT_FETCH    = 1'b0;
  localparam logic GNT_DATA     = 1'b1;
  localparam int   READ_LAT_MAX = 7;
  localparam int   CNT_W        = 3;
endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requesters.
// MEM_ARB_RR_EN: round-robin on ties (history held here); otherwise data-over-fetch priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic fetch_req,
  input  logic data_req,
  input  logic grant_en,
  output logic gnt
);

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    gnt    = GNT_FETCH;
    last_d = last_q;
    if (fetch_req && data_req) gnt = (last_q == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    else                       gnt = data_req ? GNT_DATA : GNT_FETCH;
    if (grant_en) last_d = gnt;
  end

  // Cleared history reads as "fetch went last", so the first tie goes to data.
  always_ff @(posedge clk) begin
    if (reset) last_q <= GNT_FETCH;
    else       last_q <= last_d;
  end
`else
  logic unused_pick;
  assign unused_pick = &{1'b0, clk, reset, fetch_req, grant_en};

  always_comb begin
    gnt = data_req ? GNT_DATA : GNT_FETCH;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between instruction fetch (read-only) and load/store.
// READ_LAT legal range 1..7. MEM_ARB_RR_EN selects round-robin arbitration in mem_arb_pick.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  output logic              mem_enable,
  output logic              mem_output_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(READ_LAT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gnt_q, gnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  fetch_rdata_q, fetch_rdata_d;
  logic [DATA_W-1:0]  data_rdata_q, data_rdata_d;
  logic               grant_en;
  logic               pick_gnt;

  assign grant_en = (state_q == IDLE) && (fetch_req || data_req);

  mem_arb_pick u_pick (
    .clk       (clk),
    .reset     (reset),
    .fetch_req (fetch_req),
    .data_req  (data_req),
    .grant_en  (grant_en),
    .gnt       (pick_gnt)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;
    mem_address   = '0;
    mem_load      = 1'b0;
    mem_enable    = 1'b0;
    mem_output_en = 1'b0;
    mem_wdata     = '0;
    fetch_ack     = 1'b0;
    data_ack      = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_en) begin
          state_d = ACCESS;
          gnt_d   = pick_gnt;
          cnt_d   = CNT_RELOAD;
          if (pick_gnt == GNT_DATA) begin
            addr_d  = data_addr;
            we_d    = data_we;
            wdata_d = data_wdata;
          end else begin
            addr_d  = fetch_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      ACCESS: begin
        mem_enable  = 1'b1;
        mem_address = addr_q;
        if (we_q) begin
          mem_load  = 1'b1;
          mem_wdata = wdata_q;
          state_d   = ACK;
        end else begin
          mem_output_en = 1'b1;
          // Capture on the last read cycle so rdata is valid alongside ack.
          if (cnt_q == '0) begin
            state_d = ACK;
            if (gnt_q == GNT_DATA) data_rdata_d  = mem_rdata;
            else                   fetch_rdata_d = mem_rdata;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ACK: begin
        state_d   = IDLE;
        fetch_ack = (gnt_q == GNT_FETCH);
        data_ack  = (gnt_q == GNT_DATA);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      gnt_q         <= GNT_FETCH;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign fetch_rdata = fetch_rdata_q;
  assign data_rdata  = data_rdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, ack scoreboard, corner-case sequences.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, fetch_req, data_req, data_we;
  logic [AW-1:0] fetch_addr, data_addr;
  logic [DW-1:0] data_wdata;
  logic          fetch_ack, data_ack, mem_load, mem_enable, mem_output_en, busy;
  logic [DW-1:0] fetch_rdata, data_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_address;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata),
    .mem_address(mem_address), .mem_load(mem_load), .mem_enable(mem_enable),
    .mem_output_en(mem_output_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Second instance with a longer read latency for the abort case.
  logic          rst3, freq3, dreq3, dwe3;
  logic [AW-1:0] faddr3, daddr3, mem_address3;
  logic [DW-1:0] dwd3, fetch_rdata3, data_rdata3, mem_wdata3, mem_rdata3;
  logic          fetch_ack3, data_ack3, mem_load3, mem_enable3, mem_output_en3, busy3;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut3 (
    .clk(clk), .reset(rst3),
    .fetch_req(freq3), .fetch_addr(faddr3), .fetch_ack(fetch_ack3), .fetch_rdata(fetch_rdata3),
    .data_req(dreq3), .data_we(dwe3), .data_addr(daddr3), .data_wdata(dwd3),
    .data_ack(data_ack3), .data_rdata(data_rdata3),
    .mem_address(mem_address3), .mem_load(mem_load3), .mem_enable(mem_enable3),
    .mem_output_en(mem_output_en3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  assign mem_rdata3 = mem_output_en3 ? (mem_address3 ^ 16'hA5A5) : 16'h0000;

  // Memory model: 256 words on the low address byte, preset to 0x1000 + index.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= DW'(16'h1000 + i);
    end else if (mem_enable && mem_load) begin
      mem[mem_address[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_output_en ? mem[mem_address[7:0]] : 16'hDEAD;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          chk;
    logic [DW-1:0] rdata;
  } sb_t;
  sb_t exp_f_q[$];
  sb_t exp_d_q[$];
  sb_t e_f, e_d;

  always @(negedge clk) begin
    if (!reset) begin
      if (fetch_ack) begin
        if (exp_f_q.size() == 0) check("fetch_unexpected_ack", 1, 0);
        else begin
          e_f = exp_f_q.pop_front();
          if (e_f.chk) check("sb_fetch_rdata", fetch_rdata, e_f.rdata);
        end
      end
      if (data_ack) begin
        if (exp_d_q.size() == 0) check("data_unexpected_ack", 1, 0);
        else begin
          e_d = exp_d_q.pop_front();
          if (e_d.chk) check("sb_data_rdata", data_rdata, e_d.rdata);
        end
      end
    end
  end

  typedef struct {
    logic          port;   // 1 = data, 0 = fetch
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;
  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {fetch_ack, data_ack, mem_load, mem_enable, mem_output_en, busy}, 0);
    check("rst_fetch_rdata", fetch_rdata, 0);
    check("rst_data_rdata", data_rdata, 0);
    check("rst_mem_bus", {mem_address, mem_wdata}, 0);
    reset = 1'b0;
    tick();
  endtask

  task automatic run_txn(input vec_t v);
    int   lat;
    logic got;
    sb_t  s;
    lat = 0; got = 1'b0;
    s.chk = !v.we; s.rdata = v.exp_rdata;
    if (v.port) begin
      data_req = 1'b1; data_we = v.we; data_addr = v.addr; data_wdata = v.wdata;
      exp_d_q.push_back(s);
    end else begin
      fetch_req = 1'b1; fetch_addr = v.addr;
      exp_f_q.push_back(s);
    end
    while (!got && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat == 1) begin
        check("acc_enable", mem_enable, 1);
        check("acc_addr", mem_address, v.addr);
        check("acc_load", mem_load, v.we);
        check("acc_oe", mem_output_en, !v.we);
        check("acc_wdata", mem_wdata, v.we ? v.wdata : '0);
        // Post-grant changes must not reach the memory.
        if (v.port) begin data_addr = ~v.addr; data_wdata = ~v.wdata; end
        else fetch_addr = ~v.addr;
      end
      got = v.port ? data_ack : fetch_ack;
    end
    check("txn_latency", lat, v.exp_lat);
    if (v.port) data_req = 1'b0; else fetch_req = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    if (!v.we) check("rdata_hold", v.port ? data_rdata : fetch_rdata, v.exp_rdata);
  endtask

  task automatic tie_pair(input logic exp_data_first);
    int  cyc, tf, td;
    sb_t s;
    cyc = 0; tf = 0; td = 0;
    s.chk = 1'b1;
    s.rdata = 16'h1002; exp_d_q.push_back(s);
    s.rdata = 16'h1040; exp_f_q.push_back(s);
    fetch_req = 1'b1; fetch_addr = 16'h0040;
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0002;
    while ((tf == 0 || td == 0) && cyc < 30) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (fetch_ack) begin tf = cyc; fetch_req = 1'b0; end
      if (data_ack)  begin td = cyc; data_req = 1'b0; end
    end
    fetch_req = 1'b0; data_req = 1'b0;
    check("tie_first_lat", exp_data_first ? td : tf, 2);
    check("tie_second_gap", exp_data_first ? (tf - td) : (td - tf), 3);
    tick();
  endtask

  initial begin
    int  acks, busy_n, cyc, nd, tf;
    int  dcyc [3];
    sb_t s;
    vec_t v;

    vecs[0] = '{1'b1, 1'b1, 16'h0040, 16'h1234, 16'h0000, 2};
    vecs[1] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1234, 2};
    vecs[2] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h1002, 2};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 2};
    vecs[4] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hBEEF, 2};
    vecs[5] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h1234, 2};
    vecs[6] = '{1'b0, 1'b0, 16'h0007, 16'h0000, 16'h1007, 2};

    rst3 = 1'b1; freq3 = 1'b0; dreq3 = 1'b0; dwe3 = 1'b0;
    faddr3 = '0; daddr3 = '0; dwd3 = '0;

    do_reset();
    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Requester drops req during ACCESS: the write still lands, one ack only.
    s.chk = 1'b0; s.rdata = '0; exp_d_q.push_back(s);
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0123; data_wdata = 16'h5A5A;
    @(posedge clk); @(negedge clk);
    check("drop_load", mem_load, 1);
    data_req = 1'b0;
    acks = 0; busy_n = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (data_ack) acks++;
      if (busy) busy_n++;
    end
    check("drop_ack_count", acks, 1);
    check("drop_busy_cycles", busy_n, 1);
    tick();
    v = '{1'b0, 1'b0, 16'h0123, 16'h0000, 16'h5A5A, 2};
    run_txn(v);

    // Simultaneous requests; a data-only grant in between sets RR history to data.
    do_reset();
    tie_pair(1'b1);
    v = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h1002, 2};
    run_txn(v);
`ifdef MEM_ARB_RR_EN
    tie_pair(1'b0);
`else
    tie_pair(1'b1);

    // Held data_req starves fetch until it drops.
    s.chk = 1'b0; s.rdata = '0;
    repeat (3) exp_d_q.push_back(s);
    s.chk = 1'b1; s.rdata = 16'h7777; exp_f_q.push_back(s);
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0200; data_wdata = 16'h7777;
    fetch_req = 1'b1; fetch_addr = 16'h0200;
    cyc = 0; nd = 0; tf = 0;
    for (int k = 0; k < 3; k++) dcyc[k] = 0;
    while (tf == 0 && cyc < 40) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (data_ack) begin
        if (nd < 3) dcyc[nd] = cyc;
        nd++;
        if (nd == 3) data_req = 1'b0;
      end
      if (fetch_ack) begin tf = cyc; fetch_req = 1'b0; end
    end
    data_req = 1'b0; fetch_req = 1'b0;
    check("b2b_data0", dcyc[0], 2);
    check("b2b_data1", dcyc[1], 5);
    check("b2b_data2", dcyc[2], 8);
    check("b2b_data_count", nd, 3);
    check("b2b_fetch", tf, 11);
    tick();
`endif

    check("sb_fetch_empty", exp_f_q.size(), 0);
    check("sb_data_empty", exp_d_q.size(), 0);

    // READ_LAT = 3: full read, then reset mid-read aborts everything.
    @(negedge clk); rst3 = 1'b0;
    tick();
    freq3 = 1'b1; faddr3 = 16'h0010;
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (fetch_ack3) break;
    end
    freq3 = 1'b0;
    check("rl3_latency", cyc, 4);
    check("rl3_rdata", fetch_rdata3, 16'hA5B5);
    tick();
    freq3 = 1'b1; faddr3 = 16'h0020;
    @(posedge clk); @(negedge clk);
    check("rl3_oe", mem_output_en3, 1);
    @(posedge clk); @(negedge clk);
    rst3 = 1'b1; freq3 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort_strobes", {fetch_ack3, data_ack3, mem_load3, mem_enable3, mem_output_en3, busy3}, 0);
    check("abort_rdata", {fetch_rdata3, data_rdata3}, 0);
    check("abort_bus", {mem_address3, mem_wdata3}, 0);
    rst3 = 1'b0;
    acks = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (fetch_ack3 || busy3) acks++;
    end
    check("abort_no_ack", acks, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port memory between two requesters: the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Sits between the CPU core and the memory block.
- Drives the memory's address, load, enable, output_en and data_in pins, and captures its data_out.
- Each requester uses a req/ack handshake with registered read data.

Parameters:
- ADDR_W, 16, address width of the memory and of both requester ports
- DATA_W, 16, data word width
- READ_LAT, 1, number of ACCESS cycles a read holds enable/output_en before capture; legal range 1..7

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- fetch_req  in  1  fetch read request; held high until fetch_ack
- fetch_addr  in  ADDR_W  fetch address; stable while fetch_req is high
- fetch_ack  out  1  one-cycle completion pulse
- fetch_rdata  out  DATA_W  registered read data; valid with fetch_ack, held until the next fetch completes
- data_req  in  1  load/store request; held high until data_ack
- data_we  in  1  1 = write, 0 = read; stable with data_req
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_ack  out  1  one-cycle completion pulse
- data_rdata  out  DATA_W  registered load data; valid with data_ack, held until the next data read
- mem_address  out  ADDR_W  to memory address
- mem_load  out  1  to memory load (write strobe)
- mem_enable  out  1  to memory enable
- mem_output_en  out  1  to memory output_en
- mem_wdata  out  DATA_W  to memory data_in
- mem_rdata  in  DATA_W  from memory data_out
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including both rdata registers.
  - Grant history clears so the next tie goes to data.
  - Reset during a transaction aborts it: no ack is issued and memory strobes drop at that edge.
- States:
  - IDLE -> ACCESS when either req is high; the winner is chosen combinationally that cycle.
  - On the transition, the winner's addr, we and wdata are latched; fetch is always a read.
  - ACCESS -> ACK after 1 cycle for a write, or after READ_LAT cycles for a read.
  - ACK -> IDLE unconditionally.
- ACCESS outputs:
  - mem_enable = 1 throughout, and mem_address = latched address.
  - Write: mem_load = 1 and mem_wdata = latched wdata.
  - Read: mem_output_en = 1 and mem_load = 0.
  - On the last ACCESS cycle of a read, mem_rdata is registered into the winner's rdata.
- ACK:
  - All mem_* strobes are 0.
  - The winner's ack = 1 for exactly one cycle; rdata is already valid.
- Latency from req-high-in-IDLE to ack:
  - Write: 2 cycles.
  - Read: READ_LAT + 1 cycles.
  - Minimum repeat interval: 3 cycles (write) or READ_LAT + 2 cycles (read).
- Handshake rules:
  - Req high in the IDLE cycle after an ack is a new request.
  - Req dropping mid-transaction is ignored; the transaction completes and ack still pulses.
  - Changes to addr/wdata after grant have no effect.
- Arbitration: fixed priority, data over fetch. A losing requester waits in IDLE with its req held; it does not starve while the data port idles.
- Read counter: 3-bit; it reloads on entering ACCESS, and no wrap is reachable.
- Addresses pass unchanged; the top address is legal.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On simultaneous requests, the port not granted last wins.
  - A single requester is always granted.
  - Grant history updates on each IDLE -> ACCESS transition.
- Undefined: fixed data-over-fetch priority as above, with no history register.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ACCESS, ACK)
  - grant encoding (GNT_FETCH = 0, GNT_DATA = 1)
  - READ_LAT bound constant
- Sub-module mem_arb_pick:
  - Combinational winner select from the two reqs plus last-grant bit; holds the round-robin history register under MEM_ARB_RR_EN.
  - Everything else stays in mem_arbiter.

Test Plan:
- Reset, then data write 0x1234 to address 0x0040 -> ACCESS with mem_load = 1, mem_enable = 1, mem_address = 0x0040, mem_wdata = 0x1234; data_ack one cycle later; total 2 cycles.
- Fetch read of 0x0040 with READ_LAT = 1 -> mem_output_en for 1 cycle; fetch_ack 2 cycles after req with fetch_rdata = 0x1234, held afterwards.
- fetch_req and data_req (read 0x0002) rise together:
  - Fixed priority: data served first, fetch acked 3 cycles after data_ack.
  - MEM_ARB_RR_EN: a second simultaneous pair is served fetch-first.
- data_req dropped in the ACCESS cycle -> write still occurs and data_ack still pulses once; no extra transaction follows.
- reset asserted during ACCESS of a read with READ_LAT = 3 -> next cycle all outputs 0, no ack, rdata 0, busy = 0.
- data_req held continuously with fetch_req also high under fixed priority -> back-to-back data grants every 3 cycles; fetch granted only once data_req drops.
